// File: rtl/griffin_sched.sv
// griffin_sched: round-robin scheduler sharing one serial Griffin permutation core among NUM_REQ requesters
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   req_valid/data    per-requester input words (req_data packed, requester i at [i*N_BITS +: N_BITS])
//   req_ready         one-hot word accept for the granted requester while loading
//   rsp_*             tagged result words, held stable until rsp_ready
//   busy              high whenever the scheduler is not idle
//   core_*            serial core strobes and data (core_out valid the cycle after core_rd)
//
// Build option: define GRIFFIN_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins)
// instead of round-robin arbitration.
module griffin_sched #(
   parameter int N_BITS     = 254,
   parameter int STATE_SIZE = 3,
   parameter int NUM_REQ    = 4,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*N_BITS-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [N_BITS-1:0]           rsp_data,
   output logic [ID_W-1:0]             rsp_id,
   output logic                        rsp_last,
   output logic                        busy,
   output logic                        core_reset,
   output logic                        core_wr,
   output logic                        core_rd,
   output logic                        core_enable,
   output logic [N_BITS-1:0]           core_in,
   input  logic [N_BITS-1:0]           core_out,
   input  logic                        core_done
);
   localparam int CW = $clog2(STATE_SIZE) + 1;
   localparam logic [CW-1:0] LAST = CW'(STATE_SIZE - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, FETCH, SEND} state_t;

   state_t          state;
   logic [ID_W-1:0] gnt_id;
   logic [ID_W-1:0] pick;
   logic [CW-1:0]   wcnt;
   logic [CW-1:0]   rcnt;

`ifdef GRIFFIN_SCHED_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_valid[i]) pick = ID_W'(i);
   end
`else
   logic [ID_W-1:0] last_gnt;
   logic [ID_W-1:0] cand;
   // Scan downward so the candidate nearest last_gnt+1 is the final assignment.
   always_comb begin
      pick = '0;
      cand = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         cand = ID_W'((int'(last_gnt) + i) % NUM_REQ);
         if (req_valid[cand]) pick = cand;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         gnt_id <= '0;
         wcnt   <= '0;
         rcnt   <= '0;
`ifndef GRIFFIN_SCHED_FIXED_PRIO_EN
         last_gnt <= ID_W'(NUM_REQ - 1);
`endif
      end else begin
         case (state)
            IDLE:
               if (|req_valid) begin
                  gnt_id <= pick;
                  state  <= CLEAR;
               end
            CLEAR: begin
               wcnt  <= '0;
               state <= LOAD;
            end
            LOAD:
               if (req_valid[gnt_id]) begin
                  wcnt <= wcnt + 1'b1;
                  if (wcnt == LAST) state <= RUN;
               end
            RUN:
               if (core_done) begin
                  rcnt  <= '0;
                  state <= FETCH;
               end
            FETCH: state <= SEND;
            SEND:
               if (rsp_ready) begin
                  if (rcnt == LAST) begin
`ifndef GRIFFIN_SCHED_FIXED_PRIO_EN
                     last_gnt <= gnt_id;
`endif
                     state <= IDLE;
                  end else begin
                     rcnt  <= rcnt + 1'b1;
                     state <= FETCH;
                  end
               end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy        = state != IDLE;
   assign core_reset  = reset || state == CLEAR;
   assign req_ready   = state == LOAD ? NUM_REQ'(1) << gnt_id : '0;
   assign core_wr     = state == LOAD && req_valid[gnt_id];
   assign core_in     = req_data[int'(gnt_id)*N_BITS +: N_BITS];
   // Enable drops in the same cycle done is seen so the core stops immediately.
   assign core_enable = state == RUN && !core_done;
   assign core_rd     = state == FETCH;
   assign rsp_valid   = state == SEND;
   assign rsp_data    = state == SEND ? core_out : '0;
   assign rsp_id      = state == SEND ? gnt_id : '0;
   assign rsp_last    = state == SEND && rcnt == LAST;
endmodule

// File: tb/tb_griffin_sched.sv
// tb_griffin_sched: directed scoreboard bench for griffin_sched with a behavioural serial core
module tb_griffin_sched;
   logic            clk = 0;
   logic            reset;
   logic [3:0]      req_valid;
   logic [1015:0]   req_data;
   logic [3:0]      req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [253:0]    rsp_data;
   logic [1:0]      rsp_id;
   logic            rsp_last;
   logic            busy;
   logic            core_reset;
   logic            core_wr;
   logic            core_rd;
   logic            core_enable;
   logic [253:0]    core_in;
   logic [253:0]    core_out = '0;
   logic            core_done = 0;

   griffin_sched dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_last(rsp_last), .busy(busy),
      .core_reset(core_reset), .core_wr(core_wr), .core_rd(core_rd),
      .core_enable(core_enable), .core_in(core_in), .core_out(core_out),
      .core_done(core_done)
   );

   always #5 clk = ~clk;

   // Core model: result word k is input word k plus 6; done after 10 enabled cycles.
   logic [253:0] mem [0:2];
   int wp = 0, rp = 0, ecnt = 0;
   always @(posedge clk) begin
      if (core_reset) begin
         wp <= 0; rp <= 0; ecnt <= 0; core_done <= 0;
      end else begin
         if (core_wr) begin
            mem[wp % 3] <= core_in;
            wp <= wp + 1;
         end
         if (core_enable) begin
            ecnt <= ecnt + 1;
            if (ecnt == 9) core_done <= 1;
         end
         if (core_rd) begin
            core_out <= mem[rp % 3] + 254'(6);
            rp <= rp + 1;
         end
      end
   end

   typedef struct { logic [253:0] d; logic [1:0] id; logic l; } exp_t;
   exp_t exp_q[$];
   int   gq[$];
   int   total = 0, bad = 0;
   int   n_wr = 0, n_rd = 0, n_clr = 0, resp_k = 0;
   logic clr_flag = 0;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset) resp_k = 0;
      if (core_reset && !reset) begin
         n_clr++;
         clr_flag = 1;
      end
      if (core_wr) begin
         n_wr++;
         chk("clr_before_wr", 256'(clr_flag), 256'(1));
      end
      if (core_rd) n_rd++;
      if (rsp_valid) begin
         chk("rsp_vs_ready", 256'(req_ready), 256'(0));
         if (exp_q.size() == 0) chk("sb_empty", 256'(exp_q.size()), 256'(1));
         else begin
            chk("rsp_data", 256'(rsp_data), 256'(exp_q[0].d));
            chk("rsp_id", 256'(rsp_id), 256'(exp_q[0].id));
            chk("rsp_last", 256'(rsp_last), 256'(exp_q[0].l));
            if (rsp_ready) begin
               resp_k++;
               if (exp_q[0].l) begin
                  gq.push_back(int'(rsp_id));
                  resp_k = 0;
                  clr_flag = 0;
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   int jobs[4], wc[4], gap[4], base[4];
   bit stall1 = 0, bp_arm = 0;
   int bp_cnt = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      logic [3:0] acc;
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = jobs[i] > 0 && gap[i] == 0;
         req_data[i*254 +: 254] = 254'(base[i] + wc[i]);
      end
      if (bp_arm && rsp_valid && resp_k == 1) begin
         rsp_ready = 0;
         bp_cnt = 5;
         bp_arm = 0;
      end
      if (bp_cnt > 0) begin
         chk("bp_no_rd", 256'(core_rd), 256'(0));
         chk("bp_hold_valid", 256'(rsp_valid), 256'(1));
         bp_cnt--;
      end else rsp_ready = 1;
      for (int i = 0; i < 4; i++)
         if (gap[i] > 0) chk("stall_in_load", 256'(req_ready[i]), 256'(1));
      acc = req_ready & req_valid;
      tick();
      for (int i = 0; i < 4; i++) begin
         if (gap[i] > 0) gap[i]--;
         if (acc[i]) begin
            wc[i]++;
            if (i == 1 && stall1 && wc[i] == 1) begin
               gap[i] = 3;
               stall1 = 0;
            end
            if (wc[i] == 3) begin
               for (int k = 0; k < 3; k++)
                  exp_q.push_back('{d: 254'(base[i] + k + 6), id: 2'(i), l: k == 2});
               wc[i] = 0;
               jobs[i]--;
               base[i] += 3;
            end
         end
      end
   endtask

   task automatic run(input int budget);
      int n = 0;
      while ((jobs[0] + jobs[1] + jobs[2] + jobs[3] > 0 || exp_q.size() > 0 || busy) && n < budget) begin
         step();
         n++;
      end
      chk("drain_idle", 256'({busy, exp_q.size() != 0}), 256'(0));
   endtask

   task automatic do_reset();
      reset = 1;
      req_valid = '0;
      tick();
      tick();
      reset = 0;
      #1;
   endtask

   int n0;
   int rr_exp[5];

   initial begin
      req_data = '0;
      rsp_ready = 1;
      for (int i = 0; i < 4; i++) begin
         jobs[i] = 0; wc[i] = 0; gap[i] = 0; base[i] = 10 * (i + 1);
      end
      reset = 1;
      req_valid = '0;
      tick();
      tick();
      chk("rst_core_reset", 256'(core_reset), 256'(1));
      chk("rst_req_ready", 256'(req_ready), 256'(0));
      chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
      chk("rst_rsp_last", 256'(rsp_last), 256'(0));
      chk("rst_rsp_id", 256'(rsp_id), 256'(0));
      chk("rst_rsp_data", 256'(rsp_data), 256'(0));
      chk("rst_strobes", 256'({core_wr, core_rd, core_enable}), 256'(0));
      chk("rst_busy", 256'(busy), 256'(0));
      reset = 0;
      #1;
      chk("rst_release_core_reset", 256'(core_reset), 256'(0));

      // single job from requester 2: words 1,2,3 -> results 7,8,9
      base[2] = 1;
      jobs[2] = 1;
      req_valid = 4'b0100;
      chk("latency_pre", 256'(req_ready), 256'(0));
      tick();
      chk("latency_clear", 256'({req_ready, core_reset}), 256'({4'b0000, 1'b1}));
      tick();
      chk("latency_ready", 256'(req_ready), 256'(4'b0100));
      run(200);
      chk("single_wr", 256'(n_wr), 256'(3));
      chk("single_rd", 256'(n_rd), 256'(3));
      chk("single_id", 256'(gq.size() == 1 ? gq[0] : -1), 256'(2));

      // round-robin with all requesters pending
      do_reset();
      gq.delete();
      jobs = '{2, 1, 1, 1};
`ifdef GRIFFIN_SCHED_FIXED_PRIO_EN
      rr_exp = '{0, 0, 1, 2, 3};
`else
      rr_exp = '{0, 1, 2, 3, 0};
`endif
      run(800);
      chk("rr_count", 256'(gq.size()), 256'(5));
      for (int k = 0; k < 5; k++)
         chk("rr_order", 256'(k < gq.size() ? gq[k] : -1), 256'(rr_exp[k]));

      // load stall on requester 1
      n0 = n_wr;
      stall1 = 1;
      jobs[1] = 1;
      run(200);
      chk("stall_wr_count", 256'(n_wr - n0), 256'(3));

      // response back-pressure on word 2
      n0 = n_rd;
      bp_arm = 1;
      jobs[3] = 1;
      run(200);
      chk("bp_rd_count", 256'(n_rd - n0), 256'(3));
      chk("bp_applied", 256'(bp_arm), 256'(0));

      // reset while the core is running
      jobs[0] = 1;
      for (int n = 0; n < 50 && !core_enable; n++) step();
      chk("reached_run", 256'(core_enable), 256'(1));
      reset = 1;
      exp_q.delete();
      #1;
      chk("midrst_core_reset", 256'(core_reset), 256'(1));
      chk("midrst_rsp_valid", 256'(rsp_valid), 256'(0));
      tick();
      reset = 0;
      #1;
      chk("midrst_idle", 256'(busy), 256'(0));
      gq.delete();
      jobs[0] = 1;
      run(200);
      chk("after_rst_id", 256'(gq.size() == 1 ? gq[0] : -1), 256'(0));

      // clear once per job across two back-to-back jobs
      n0 = n_clr;
      jobs[0] = 1;
      jobs[1] = 1;
      run(400);
      chk("clr_per_job", 256'(n_clr - n0), 256'(2));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
